axi_burst_arbiter: RTL
======================

Name: axi_burst_arbiter

Overview:
- Sits directly downstream of the I-cache and D-cache burst masters and merges them onto one AXI3 master port toward the SoC bus.
- I-side is read-only. D-side carries both read and write-back bursts.
- Allows one outstanding read (round-robin I/D) and one outstanding write (D only).
- Blocks a D read that hits the same cache line as an in-flight write-back.

Parameters:
- I_ID, 4'd0, ARID driven for I-side reads.
- D_ID, 4'd1, ARID/AWID/WID driven for D-side transactions.
- LINE_OFFSET, 5, low address bits ignored in the read-after-write line compare (32-byte line).
- D_FIRST, 1, reset value of the priority pointer; 1 = D wins the first tie.

Ports:
- clk input 1: clock, all state on rising edge.
- rst input 1: reset, asynchronous, active-low (0 = reset).
- i_araddr/i_arlen/i_arsize input 32/4/3: I-side read request.
- i_arvalid input 1, i_arready output 1: I-side AR handshake.
- i_rdata input... no: i_rdata output 32, i_rlast output 1, i_rvalid output 1: I-side read data.
- i_rready input 1: I-side read-data accept.
- d_araddr/d_arlen/d_arsize input 32/4/3, d_arvalid input 1, d_arready output 1: D-side read request.
- d_rdata output 32, d_rlast output 1, d_rvalid output 1, d_rready input 1: D-side read data.
- d_awaddr/d_awlen/d_awsize input 32/4/3, d_awvalid input 1, d_awready output 1: D-side write address.
- d_wdata input 32, d_wstrb input 4, d_wlast input 1, d_wvalid input 1, d_wready output 1: D-side write data.
- d_bvalid output 1, d_bready input 1: D-side write response.
- m_arid output 4, m_araddr output 32, m_arlen output 4, m_arsize output 3, m_arburst output 2, m_arvalid output 1, m_arready input 1: bus AR channel.
- m_rid input 4, m_rdata input 32, m_rresp input 2, m_rlast input 1, m_rvalid input 1, m_rready output 1: bus R channel.
- m_awid output 4, m_awaddr output 32, m_awlen output 4, m_awsize output 3, m_awburst output 2, m_awvalid output 1, m_awready input 1: bus AW channel.
- m_wid output 4, m_wdata output 32, m_wstrb output 4, m_wlast output 1, m_wvalid output 1, m_wready input 1: bus W channel.
- m_bid input 4, m_bresp input 2, m_bvalid input 1, m_bready output 1: bus B channel.

Behaviour:
- Reset (rst=0, asynchronous): read FSM = R_IDLE, write FSM = W_IDLE, grant = I, prio = D_FIRST, hazard line = 0. Every valid/ready output is 0.
- m_arburst and m_awburst are always 2'b01 (INCR). m_awid and m_wid are always D_ID.
- Read FSM, R_IDLE:
  - d_ok = d_arvalid && !(wr_busy && d_araddr[31:LINE_OFFSET]==haz_line).
  - Candidates are i_arvalid and d_ok.
  - One candidate → grant it. Both → grant D if prio=1, else I; prio then toggles to point at the loser.
  - Any grant → R_ADDR next cycle. This gives a one-cycle arbitration bubble: m_arvalid first rises the cycle after x_arvalid.
- R_ADDR:
  - m_ar* = granted source's live ar* fields; m_arid = I_ID or D_ID.
  - m_arvalid = granted x_arvalid; granted x_arready = m_arready; non-granted x_arready = 0.
  - m_arvalid && m_arready → R_DATA.
  - Granted source drops arvalid (protocol error) → R_IDLE, no bus beat issued.
- R_DATA:
  - m_rdata and m_rlast go to the granted side; granted x_rvalid = m_rvalid; m_rready = granted x_rready.
  - Other side's rvalid = 0.
  - Beat with m_rlast accepted → R_IDLE. A new grant is possible in that same R_IDLE cycle's evaluation on the next edge.
  - m_rid and m_rresp are ignored; routing is by grant only.
- Write FSM, W_IDLE:
  - d_awvalid → W_ADDR; latch haz_line = d_awaddr[31:LINE_OFFSET].
  - wr_busy = (state != W_IDLE).
- W_ADDR: m_aw* = d_aw*; m_awvalid = d_awvalid; d_awready = m_awready. Handshake → W_DATA.
- W_DATA: m_w* = d_w*; m_wvalid = d_wvalid; d_wready = m_wready. Beat with d_wlast accepted → W_RESP.
- W_RESP: d_bvalid = m_bvalid; m_bready = d_bready. Handshake → W_IDLE and hazard released. m_bresp is ignored.
- W and R FSMs run concurrently and independently, except for the hazard stall.
- Simultaneous events:
  - A write starting in the same cycle as a D read grant does not cancel the read; the hazard is checked only at grant time.
  - When the write completes in the same cycle a D read is pending, the read is granted on the following R_IDLE evaluation.
- Reset mid-burst: both FSMs abort immediately; nothing is forwarded after reset deasserts until a fresh request arrives.

Test Plan:
- Only i_arvalid, addr 0x1FC0_0000, len 7: m_arvalid at cycle+1 with arid 0, arlen 7, burst 01. 8 beats appear on i_r*; d_rvalid stays 0; FSM returns to R_IDLE after rlast.
- i_arvalid and d_arvalid together from reset: D granted first (arid 1). After its rlast, I is granted. Repeat both together: I is granted (prio toggled).
- D write-back to 0x8000_0040 (8 beats, wready stalls on beats 3 and 6): all 8 beats are forwarded with wid 1, m_wlast only on beat 8, d_bvalid mirrors m_bvalid.
- D write in flight to line 0x8000_0040, then d_araddr 0x8000_0044: d_arready stays 0 until the B handshake completes, while a concurrent i_arvalid is granted meanwhile. D read to 0x8000_0080 during the same write is granted without stall.
- rst pulled low during beat 4 of a D read: all m_*valid/ready and x_*valid/ready outputs drop to 0 asynchronously; the next request after release starts cleanly in R_IDLE.

Source files
------------

// File: rtl/axi_burst_arbiter.sv
// Merges I-cache and D-cache burst masters onto one AXI3 port.
// One outstanding read (round-robin I/D), one outstanding D write.
module axi_burst_arbiter #(
  parameter logic [3:0] I_ID        = 4'd0,
  parameter logic [3:0] D_ID        = 4'd1,
  parameter int         LINE_OFFSET = 5,
  parameter bit         D_FIRST     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [3:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [3:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  input  logic [31:0] d_awaddr,
  input  logic [3:0]  d_awlen,
  input  logic [2:0]  d_awsize,
  input  logic        d_awvalid,
  output logic        d_awready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [3:0]  m_awid,
  output logic [31:0] m_awaddr,
  output logic [3:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [3:0]  m_wid,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [3:0]  m_bid,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

  localparam int HW = 32 - LINE_OFFSET;

  r_state_e        r_q, r_d;
  w_state_e        w_q, w_d;
  logic            gnt_q, gnt_d;
  logic            prio_q, prio_d;
  logic [HW-1:0]   haz_q, haz_d;
  logic            wr_busy;
  logic            d_ok;
  logic            sel_arvalid;
  logic            sel_rready;
  logic            unused_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= R_IDLE;
      w_q    <= W_IDLE;
      gnt_q  <= 1'b0;
      prio_q <= D_FIRST;
      haz_q  <= '0;
    end else begin
      r_q    <= r_d;
      w_q    <= w_d;
      gnt_q  <= gnt_d;
      prio_q <= prio_d;
      haz_q  <= haz_d;
    end
  end

  // A D read to the line being written back must wait for the B response.
  assign wr_busy = (w_q != W_IDLE);
  assign d_ok    = d_arvalid &&
                   !(wr_busy && d_araddr[31:LINE_OFFSET] == haz_q);

  assign sel_arvalid = gnt_q ? d_arvalid : i_arvalid;
  assign sel_rready  = gnt_q ? d_rready : i_rready;

  always_comb begin
    r_d       = r_q;
    gnt_d     = gnt_q;
    prio_d    = prio_q;
    m_arvalid = 1'b0;
    i_arready = 1'b0;
    d_arready = 1'b0;
    m_rready  = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    unique case (r_q)
      R_IDLE: begin
        if (i_arvalid && d_ok) begin
          gnt_d  = prio_q;
          prio_d = !prio_q;
          r_d    = R_ADDR;
        end else if (d_ok) begin
          gnt_d = 1'b1;
          r_d   = R_ADDR;
        end else if (i_arvalid) begin
          gnt_d = 1'b0;
          r_d   = R_ADDR;
        end
      end
      R_ADDR: begin
        m_arvalid = sel_arvalid;
        i_arready = !gnt_q && m_arready;
        d_arready = gnt_q && m_arready;
        if (!sel_arvalid)
          r_d = R_IDLE;
        else if (m_arready)
          r_d = R_DATA;
      end
      R_DATA: begin
        m_rready = sel_rready;
        i_rvalid = !gnt_q && m_rvalid;
        d_rvalid = gnt_q && m_rvalid;
        if (m_rvalid && sel_rready && m_rlast)
          r_d = R_IDLE;
      end
      default: r_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_d       = w_q;
    haz_d     = haz_q;
    m_awvalid = 1'b0;
    d_awready = 1'b0;
    m_wvalid  = 1'b0;
    d_wready  = 1'b0;
    m_bready  = 1'b0;
    d_bvalid  = 1'b0;
    unique case (w_q)
      W_IDLE: begin
        if (d_awvalid) begin
          w_d   = W_ADDR;
          haz_d = d_awaddr[31:LINE_OFFSET];
        end
      end
      W_ADDR: begin
        m_awvalid = d_awvalid;
        d_awready = m_awready;
        if (d_awvalid && m_awready)
          w_d = W_DATA;
      end
      W_DATA: begin
        m_wvalid = d_wvalid;
        d_wready = m_wready;
        if (d_wvalid && m_wready && d_wlast)
          w_d = W_RESP;
      end
      W_RESP: begin
        d_bvalid = m_bvalid;
        m_bready = d_bready;
        if (m_bvalid && d_bready)
          w_d = W_IDLE;
      end
      default: w_d = W_IDLE;
    endcase
  end

  assign m_arid    = gnt_q ? D_ID : I_ID;
  assign m_araddr  = gnt_q ? d_araddr : i_araddr;
  assign m_arlen   = gnt_q ? d_arlen : i_arlen;
  assign m_arsize  = gnt_q ? d_arsize : i_arsize;
  assign m_arburst = 2'b01;

  assign i_rdata = m_rdata;
  assign i_rlast = m_rlast;
  assign d_rdata = m_rdata;
  assign d_rlast = m_rlast;

  assign m_awid    = D_ID;
  assign m_awaddr  = d_awaddr;
  assign m_awlen   = d_awlen;
  assign m_awsize  = d_awsize;
  assign m_awburst = 2'b01;

  assign m_wid   = D_ID;
  assign m_wdata = d_wdata;
  assign m_wstrb = d_wstrb;
  assign m_wlast = d_wlast;

  // Routing is by grant only; IDs and responses from the bus are dropped.
  assign unused_ok = ^{m_rid, m_rresp, m_bid, m_bresp};

endmodule
